// File: rtl/ctr_uart_reporter.sv
// Snapshots a counter value on trigger and sends it as uppercase hex + CR LF over 8N1 UART.
// Optional AUTO_REPORT_EN adds a free-running period counter that triggers reports on its own.
module ctr_uart_reporter #(
    parameter int VALUE_WIDTH   = 24,
    parameter int CLK_DIV       = 104,
    parameter int REPORT_PERIOD = 12000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   trigger,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic                   dropped
);
    localparam int DIGITS = VALUE_WIDTH / 4;
    localparam int BW     = $clog2(CLK_DIV);
    localparam int IW     = $clog2(DIGITS + 2);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

    if (VALUE_WIDTH < 4 || VALUE_WIDTH % 4 != 0) begin : g_bad_width
        $error("VALUE_WIDTH must be a positive multiple of 4");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be >= 2");
    end
    if (REPORT_PERIOD < 2) begin : g_bad_period
        $error("REPORT_PERIOD must be >= 2");
    end

    typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_e;

    state_e                 state_q;
    logic [BW-1:0]          baud_q;
    logic [2:0]             bit_q;
    logic [IW-1:0]          idx_q;
    logic [VALUE_WIDTH-1:0] snap_q;
    logic                   tx_q, busy_q, done_q, dropped_q;
    logic                   start_c;
    logic [3:0]             nib_c;
    logic [7:0]             char_c;
    int                     sh;

`ifdef AUTO_REPORT_EN
    localparam int PW = $clog2(REPORT_PERIOD);
    logic [PW-1:0] per_q;
    logic          auto_c;

    assign auto_c  = (per_q == PW'(REPORT_PERIOD - 1));
    assign start_c = trigger | auto_c;

    always_ff @(posedge clk) begin
        if (rst || auto_c) per_q <= '0;
        else               per_q <= per_q + PW'(1);
    end
`else
    assign start_c = trigger;
`endif

    // Current character: hex digit of the snapshot (MS nibble first), then CR, then LF.
    always_comb begin
        sh = 0;
        for (int d = 0; d < DIGITS; d++)
            if (idx_q == IW'(d)) sh = VALUE_WIDTH - 4 - 4 * d;
        nib_c = 4'(snap_q >> sh);
        if (idx_q < IW'(DIGITS))
            char_c = (nib_c < 4'd10) ? 8'h30 + {4'h0, nib_c} : 8'h37 + {4'h0, nib_c};
        else if (idx_q == IW'(DIGITS))
            char_c = 8'h0D;
        else
            char_c = 8'h0A;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            idx_q     <= '0;
            snap_q    <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Only the external trigger counts as a dropped request.
            if (trigger && busy_q) dropped_q <= 1'b1;
            if (state_q == IDLE) begin
                if (start_c) begin
                    snap_q  <= value;
                    state_q <= START_BIT;
                    busy_q  <= 1'b1;
                    tx_q    <= 1'b0;
                    baud_q  <= '0;
                    idx_q   <= '0;
                end
            end else begin
                baud_q <= (baud_q == BAUD_LAST) ? '0 : baud_q + BW'(1);
                if (baud_q == BAUD_LAST) begin
                    case (state_q)
                        START_BIT: begin
                            state_q <= DATA_BITS;
                            bit_q   <= '0;
                            tx_q    <= char_c[0];
                        end
                        DATA_BITS: begin
                            if (bit_q == 3'd7) begin
                                state_q <= STOP_BIT;
                                tx_q    <= 1'b1;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                tx_q  <= char_c[bit_q + 3'd1];
                            end
                        end
                        STOP_BIT: begin
                            if (idx_q < IW'(DIGITS + 1)) begin
                                idx_q   <= idx_q + IW'(1);
                                state_q <= START_BIT;
                                tx_q    <= 1'b0;
                            end else begin
                                idx_q   <= '0;
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                tx_q    <= 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dropped = dropped_q;
endmodule

// File: tb/tb_ctr_uart_reporter.sv
// Randomized self-checking bench: logs tx/busy/done/dropped per cycle and decodes frames against an ASCII model.
module tb_ctr_uart_reporter;
    localparam int CD    = 4;
    localparam int FRAME = 320;
    localparam int MAXL  = 1700;
`ifdef AUTO_REPORT_EN
    localparam int IDLE_WIN = 300;
`else
    localparam int IDLE_WIN = 500;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic [23:0] value = '0;
    logic        tx, busy, done, dropped;

    int n_checks = 0;
    int n_fail   = 0;

    logic tx_log[MAXL], busy_log[MAXL], done_log[MAXL], drop_log[MAXL];

    ctr_uart_reporter #(.VALUE_WIDTH(24), .CLK_DIV(CD), .REPORT_PERIOD(400)) dut (
        .clk(clk), .rst(rst), .value(value), .trigger(trigger),
        .tx(tx), .busy(busy), .done(done), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // Expected character c of the frame for value v.
    function automatic logic [7:0] exp_char(logic [23:0] v, int c);
        string hexs = "0123456789ABCDEF";
        int n;
        if (c == 6) return 8'h0D;
        if (c == 7) return 8'h0A;
        n = int'((v >> (4 * (5 - c))) & 24'hF);
        return hexs[n];
    endfunction

    // Sample the middle of each bit of char c of a frame starting at log cycle base: {stop,data,start}.
    function automatic logic [9:0] rx_char(int base, int c);
        logic [9:0] r;
        for (int b = 0; b < 10; b++) r[b] = tx_log[base + (c * 10 + b) * CD + CD / 2];
        return r;
    endfunction

    function automatic int cnt_busy(int from, int to);
        int n = 0;
        for (int k = from; k <= to; k++) n += int'(busy_log[k]);
        return n;
    endfunction

    function automatic int cnt_done(int from, int to);
        int n = 0;
        for (int k = from; k <= to; k++) n += int'(done_log[k]);
        return n;
    endfunction

    // Cycle k of the log is the k-th cycle after the edge that first sees trigger=trig0.
    task automatic run_log(input logic [23:0] v, input bit trig0, input int n, input int trig_off,
                           input int trig2_at, input int chg_at, input logic [23:0] v2, input int rst_at);
        @(negedge clk);
        value = v; trigger = trig0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tx_log[k] = tx; busy_log[k] = busy; done_log[k] = done; drop_log[k] = dropped;
            if (k == trig_off) trigger = 1'b0;
            if (trig2_at >= 0 && k == trig2_at) trigger = 1'b1;
            if (trig2_at >= 0 && k == trig2_at + 1) trigger = 1'b0;
            if (k == chg_at) value = v2;
            if (k == rst_at) rst = 1'b1;
            if (rst_at >= 0 && k == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; trigger = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int ok;
        @(negedge clk);
        rst = 1'b1; trigger = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx, busy, done, dropped} !== 4'b1000) begin
            n_fail++; $display("FAIL reset_state: got %b want 1000", {tx, busy, done, dropped});
        end
        rst = 1'b0;
        run_log(24'h0, 1'b0, IDLE_WIN, -1, -1, -1, 24'h0, -1);
        ok = 0;
        for (int k = 0; k < IDLE_WIN; k++)
            if (tx_log[k] === 1'b1 && busy_log[k] === 1'b0 && done_log[k] === 1'b0 && drop_log[k] === 1'b0) ok++;
        n_checks++;
        if (ok !== IDLE_WIN) begin
            n_fail++; $display("FAIL reset_idle: idle cycles %0d want %0d", ok, IDLE_WIN);
        end
    endtask

    task automatic test_frame();
        logic [23:0] v;
        for (int it = 0; it < 4; it++) begin
            v = (it == 0) ? 24'h00A5F3 : 24'($urandom);
            run_log(v, 1'b1, 330, 0, -1, -1, 24'h0, -1);
            n_checks++;
            if (tx_log[0] !== 1'b0) begin
                n_fail++; $display("FAIL frame_start_latency: tx %b want 0", tx_log[0]);
            end
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (rx_char(0, c) !== {1'b1, exp_char(v, c), 1'b0}) begin
                    n_fail++; $display("FAIL frame_char%0d v=%h: got %h want %h", c, v, rx_char(0, c), {1'b1, exp_char(v, c), 1'b0});
                end
            end
            n_checks++;
            if (cnt_busy(0, 329) !== FRAME || busy_log[319] !== 1'b1 || busy_log[320] !== 1'b0) begin
                n_fail++; $display("FAIL frame_busy_len: got %0d want %0d", cnt_busy(0, 329), FRAME);
            end
            n_checks++;
            if (cnt_done(0, 329) !== 1 || done_log[320] !== 1'b1) begin
                n_fail++; $display("FAIL frame_done: pulses %0d at320=%b want 1 at 320", cnt_done(0, 329), done_log[320]);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [23:0] v1, v2;
        for (int it = 0; it < 2; it++) begin
            v1 = (it == 0) ? 24'h123456 : 24'($urandom);
            v2 = (it == 0) ? 24'hFFFFFF : ~v1;
            run_log(v1, 1'b1, 330, 0, -1, 50, v2, -1);
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (rx_char(0, c) !== {1'b1, exp_char(v1, c), 1'b0}) begin
                    n_fail++; $display("FAIL snapshot_char%0d: got %h want %h", c, rx_char(0, c), {1'b1, exp_char(v1, c), 1'b0});
                end
            end
            run_log(v2, 1'b1, 330, 0, -1, -1, 24'h0, -1);
            for (int c = 0; c < 8; c++) begin
                n_checks++;
                if (rx_char(0, c) !== {1'b1, exp_char(v2, c), 1'b0}) begin
                    n_fail++; $display("FAIL snapshot_next_char%0d: got %h want %h", c, rx_char(0, c), {1'b1, exp_char(v2, c), 1'b0});
                end
            end
        end
    endtask

    task automatic test_dropped();
        logic [23:0] v;
        v = 24'($urandom);
        do_reset();
        run_log(v, 1'b1, 340, 0, 100, -1, 24'h0, -1);
        n_checks++;
        if ({drop_log[100], drop_log[101], drop_log[339]} !== 3'b011) begin
            n_fail++; $display("FAIL dropped_sticky: got %b want 011", {drop_log[100], drop_log[101], drop_log[339]});
        end
        n_checks++;
        if (cnt_busy(0, 339) !== FRAME || cnt_done(0, 339) !== 1) begin
            n_fail++; $display("FAIL dropped_single_frame: busy %0d done %0d want %0d 1", cnt_busy(0, 339), cnt_done(0, 339), FRAME);
        end
        n_checks++;
        if (rx_char(0, 2) !== {1'b1, exp_char(v, 2), 1'b0}) begin
            n_fail++; $display("FAIL dropped_frame_char: got %h want %h", rx_char(0, 2), {1'b1, exp_char(v, 2), 1'b0});
        end
        do_reset();
        n_checks++;
        if (dropped !== 1'b0) begin
            n_fail++; $display("FAIL dropped_clear: got %b want 0", dropped);
        end
        // Trigger in the final stop-bit cycle is dropped, not queued.
        run_log(v, 1'b1, 340, 0, 319, -1, 24'h0, -1);
        n_checks++;
        if ({drop_log[319], drop_log[320], busy_log[321]} !== 3'b010 || cnt_busy(0, 339) !== FRAME) begin
            n_fail++; $display("FAIL dropped_last_stop: got %b busy %0d want 010 %0d", {drop_log[319], drop_log[320], busy_log[321]}, cnt_busy(0, 339), FRAME);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] v;
        v = 24'($urandom);
        do_reset();
        run_log(v, 1'b1, 660, 325, -1, -1, 24'h0, -1);
        n_checks++;
        if ({drop_log[0], drop_log[1]} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_dropped: got %b want 01", {drop_log[0], drop_log[1]});
        end
        n_checks++;
        if ({done_log[320], busy_log[320], tx_log[321], busy_log[321]} !== 4'b1001) begin
            n_fail++; $display("FAIL b2b_gap: got %b want 1001", {done_log[320], busy_log[320], tx_log[321], busy_log[321]});
        end
        n_checks++;
        if (cnt_done(0, 659) !== 2 || done_log[641] !== 1'b1) begin
            n_fail++; $display("FAIL b2b_done: pulses %0d at641=%b want 2 1", cnt_done(0, 659), done_log[641]);
        end
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (rx_char(321, c) !== {1'b1, exp_char(v, c), 1'b0}) begin
                n_fail++; $display("FAIL b2b_char%0d: got %h want %h", c, rx_char(321, c), {1'b1, exp_char(v, c), 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] v;
        v = 24'($urandom);
        run_log(v, 1'b1, 340, 0, -1, -1, 24'h0, 150);
        n_checks++;
        if ({tx_log[151], busy_log[151]} !== 2'b10 || cnt_busy(151, 339) !== 0) begin
            n_fail++; $display("FAIL resetmid_abort: got %b busy %0d want 10 0", {tx_log[151], busy_log[151]}, cnt_busy(151, 339));
        end
        n_checks++;
        if (cnt_done(0, 339) !== 0) begin
            n_fail++; $display("FAIL resetmid_done: got %0d want 0", cnt_done(0, 339));
        end
        v = 24'($urandom);
        run_log(v, 1'b1, 330, 0, -1, -1, 24'h0, -1);
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (rx_char(0, c) !== {1'b1, exp_char(v, c), 1'b0}) begin
                n_fail++; $display("FAIL resetmid_char%0d: got %h want %h", c, rx_char(0, c), {1'b1, exp_char(v, c), 1'b0});
            end
        end
        n_checks++;
        if (cnt_busy(0, 329) !== FRAME || cnt_done(0, 329) !== 1) begin
            n_fail++; $display("FAIL resetmid_frame: busy %0d done %0d want %0d 1", cnt_busy(0, 329), cnt_done(0, 329), FRAME);
        end
    endtask

`ifdef AUTO_REPORT_EN
    task automatic test_auto();
        int starts[$];
        int drops;
        do_reset();
        run_log(24'h000010, 1'b0, 1300, -1, -1, -1, 24'h0, -1);
        drops = 0;
        for (int k = 1; k < 1300; k++) begin
            if (busy_log[k] === 1'b1 && busy_log[k-1] === 1'b0) starts.push_back(k);
            drops += int'(drop_log[k]);
        end
        n_checks++;
        if (starts.size() !== 3 || starts[0] !== 398) begin
            n_fail++; $display("FAIL auto_starts: count %0d first %0d want 3 398", starts.size(), starts.size() ? starts[0] : -1);
        end
        for (int i = 1; i < starts.size(); i++) begin
            n_checks++;
            if (starts[i] - starts[i-1] !== 400) begin
                n_fail++; $display("FAIL auto_period: got %0d want 400", starts[i] - starts[i-1]);
            end
        end
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (rx_char(398, c) !== {1'b1, exp_char(24'h000010, c), 1'b0}) begin
                n_fail++; $display("FAIL auto_char%0d: got %h want %h", c, rx_char(398, c), {1'b1, exp_char(24'h000010, c), 1'b0});
            end
        end
        n_checks++;
        if (drops !== 0) begin
            n_fail++; $display("FAIL auto_dropped: got %0d want 0", drops);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUTO_REPORT_EN
        test_auto();
`else
        test_frame();
        test_snapshot();
        test_dropped();
        test_back_to_back();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ctr_uart_reporter.md
Name: ctr_uart_reporter

Overview:
Downstream consumer of the fabric user-design counter. It snapshots a VALUE_WIDTH-bit counter value on a trigger and serialises it as uppercase ASCII hex followed by CR LF over an 8N1 UART tx line. The tx line drives one io_out pin so counter state can be read on a host terminal instead of probing pins. It sits between the counter/prescaler logic and the io_out/io_oeb assignment in the fabric top.

Parameters:
VALUE_WIDTH, 24, width of captured value; must be a multiple of 4; DIGITS = VALUE_WIDTH/4
CLK_DIV, 104, clk cycles per UART bit; must be >= 2
REPORT_PERIOD, 12000000, auto-trigger period in clk cycles; used only with AUTO_REPORT_EN

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
value  input  VALUE_WIDTH  counter value to report
trigger  input  1  request report; sampled each clk edge
tx  output  1  UART serial out; idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame
dropped  output  1  sticky: a trigger arrived while busy

Behaviour:
- Reset (rst=1 at a clk edge): tx=1, busy=0, done=0, dropped=0, state IDLE, snapshot=0, baud counter=0, char index=0. Reset mid-frame aborts the frame: tx=1 from the next edge, no done pulse.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: tx=1, busy=0. If trigger=1 at edge E, value is captured into the snapshot at E. State goes to START_BIT with busy=1 and tx=0 from E+1.
- Baud counter: counts 0..CLK_DIV-1 and wraps. A bit period ends when the count equals CLK_DIV-1. Every bit lasts exactly CLK_DIV cycles.
- START_BIT: tx=0 for one bit period, then DATA_BITS.
- DATA_BITS: 8 bits, LSB first, one bit period each, then STOP_BIT.
- STOP_BIT: tx=1 for one bit period.
  - If the char index is below DIGITS+1: increment the index and go to START_BIT. There is no idle gap between chars.
  - Otherwise: go to IDLE.
- Frame content: DIGITS hex chars, most-significant nibble first, then 0x0D, then 0x0A.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46 (uppercase).
- Frame duration: busy is high for exactly (DIGITS+2)*10*CLK_DIV cycles.
- done: asserted for the single first IDLE cycle after a completed frame. busy=0 in that cycle.
- Snapshot isolation: changes on value while busy=1 do not affect the frame.
- Trigger while busy=1 (including the final stop-bit cycle): ignored and dropped set to 1. dropped is cleared only by rst.
- Trigger in the done cycle is accepted, since the state is IDLE. This gives back-to-back frames separated by one idle cycle.
- Trigger held high continuously: a new frame starts on each IDLE cycle, and dropped sets during the first frame.
- Hex conversion is combinational from the current nibble selected by the char index. No extra latency is allowed.

Optional Feature:
Macro AUTO_REPORT_EN.
- Defined:
  - An internal period counter 0..REPORT_PERIOD-1 runs from reset.
  - On wrap it produces a one-cycle internal trigger, ORed with the trigger port.
  - An internal trigger that arrives while busy is ignored and does NOT set dropped. Only an external trigger sets dropped.
- Undefined: no period counter is instantiated; REPORT_PERIOD is unused; only the trigger port starts frames.

Test Plan:
1. rst=1 for 3 cycles, trigger=0 -> tx=1, busy=0, done=0, dropped=0 for 500 cycles after release.
2. CLK_DIV=4, value=24'h00A5F3, one-cycle trigger -> tx decodes 0x30,0x30,0x41,0x35,0x46,0x33,0x0D,0x0A; tx=0 on the cycle after trigger; busy high exactly 320 cycles; one done pulse.
3. CLK_DIV=4, value=24'h123456, trigger, then value=24'hFFFFFF at cycle 50 -> frame is "123456\r\n"; a following trigger sends "FFFFFF\r\n".
4. CLK_DIV=4, trigger at cycle 0 and cycle 100 -> exactly one frame; dropped=1 from cycle 101 and still 1 after done; rst clears it.
5. CLK_DIV=4, rst pulsed at cycle 150 of a frame -> tx=1 and busy=0 on the next cycle; no done pulse; a new trigger produces a complete correct frame.
6. AUTO_REPORT_EN, CLK_DIV=4, REPORT_PERIOD=400, value=24'h000010, trigger=0 -> frames "000010\r\n" start every 400 cycles; dropped stays 0.
